// File: rtl/ex_stage.sv
// Execute stage: computes ALU results for the ID/EX operands, registers them into EX/MEM,
// runs shifts iteratively (stalling decode) and drives the combinational EX-forwarding bus.
`ifndef EX_STAGE_DEFINES
`define EX_STAGE_DEFINES
`define InstAddrBus 31:0
`define AluOpBus    7:0
`define AluSelBus   2:0
`define RegBus      31:0
`define RegAddrBus  4:0

`define EXE_NOP_OP    8'h00
`define EXE_ADD_OP    8'h01
`define EXE_ADDI_OP   8'h02
`define EXE_SUB_OP    8'h03
`define EXE_SUBI_OP   8'h04
`define EXE_SLT_OP    8'h05
`define EXE_SLTI_OP   8'h06
`define EXE_SLTU_OP   8'h07
`define EXE_SLTIU_OP  8'h08
`define EXE_AND_OP    8'h09
`define EXE_ANDI_OP   8'h0a
`define EXE_OR_OP     8'h0b
`define EXE_ORI_OP    8'h0c
`define EXE_XOR_OP    8'h0d
`define EXE_XORI_OP   8'h0e
`define EXE_LUI_OP    8'h0f
`define EXE_AUIPC_OP  8'h10
`define EXE_SLL_OP    8'h11
`define EXE_SLLI_OP   8'h12
`define EXE_SRL_OP    8'h13
`define EXE_SRLI_OP   8'h14
`define EXE_SRA_OP    8'h15
`define EXE_SRAI_OP   8'h16

`define EXE_RES_NOP   3'b000
`define EXE_RES_LOGIC 3'b001
`define EXE_RES_SHIFT 3'b010
`define EXE_RES_ARITH 3'b100
`endif

module ex_stage #(
  parameter int SHIFT_STEP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [`InstAddrBus] pc_i,
  input  logic [`AluOpBus]    aluop_i,
  input  logic [`AluSelBus]   alusel_i,
  input  logic [`RegBus]      reg1_i,
  input  logic [`RegBus]      reg2_i,
  input  logic [`RegAddrBus]  wd_i,
  input  logic                wreg_i,
  output logic                stallreq,
  output logic                fwd_wreg_o,
  output logic [`RegAddrBus]  fwd_wd_o,
  output logic [`RegBus]      fwd_wdata_o,
  output logic                wreg_o,
  output logic [`RegAddrBus]  wd_o,
  output logic [`RegBus]      wdata_o,
  output logic                dbg_state
);

  // Handshake: while stallreq=1 the upstream holds ID and ID/EX stable; this stage
  // consumes the presented op on the first edge where stallreq=0 (or flush/rst).
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] K_SLL = 2'd0;
  localparam logic [1:0] K_SRL = 2'd1;
  localparam logic [1:0] K_SRA = 2'd2;
  localparam logic [5:0] STEP6 = 6'(SHIFT_STEP);

  state_t            state, state_nxt;
  logic [31:0]       acc;
  logic [5:0]        cnt;
  logic [1:0]        sh_kind;
  logic [4:0]        sh_wd;
  logic              sh_wreg;

  logic [4:0]        shamt;
  logic              is_shift_op;
  logic [1:0]        kind_in;
  logic              start;
  logic              final_cycle;
  logic              out_valid;
  logic [31:0]       arith_res;
  logic [31:0]       logic_res;
  logic [31:0]       single_res;
  logic [31:0]       acc_step;
  logic [31:0]       shift_out;
  logic              cand_wreg;
  logic [4:0]        cand_wd;
  logic [31:0]       cand_data;

  // SRA keeps acc's sign bit at the original r1[31] on every step, so an
  // arithmetic shift of acc always fills with the original sign.
  function automatic logic [31:0] do_shift(input logic [1:0] kind, input logic [31:0] val,
                                           input logic [5:0] amt);
    logic [31:0] r;
    case (kind)
      K_SLL:   r = val << amt;
      K_SRL:   r = val >> amt;
      K_SRA:   r = 32'($signed(val) >>> amt);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign shamt = reg2_i[4:0];

  always_comb begin
    is_shift_op = 1'b1;
    kind_in     = K_SLL;
    case (aluop_i)
      `EXE_SLL_OP, `EXE_SLLI_OP: kind_in = K_SLL;
      `EXE_SRL_OP, `EXE_SRLI_OP: kind_in = K_SRL;
      `EXE_SRA_OP, `EXE_SRAI_OP: kind_in = K_SRA;
      default:                   is_shift_op = 1'b0;
    endcase
  end

  always_comb begin
    arith_res = 32'd0;
    logic_res = 32'd0;
    case (aluop_i)
      `EXE_ADD_OP, `EXE_ADDI_OP:   arith_res = reg1_i + reg2_i;
      `EXE_SUB_OP, `EXE_SUBI_OP:   arith_res = reg1_i - reg2_i;
      `EXE_SLT_OP, `EXE_SLTI_OP:   arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
      `EXE_SLTU_OP, `EXE_SLTIU_OP: arith_res = {31'd0, reg1_i < reg2_i};
      `EXE_LUI_OP:                 arith_res = reg1_i;
      `EXE_AUIPC_OP:               arith_res = pc_i + reg1_i;
      `EXE_AND_OP, `EXE_ANDI_OP:   logic_res = reg1_i & reg2_i;
      `EXE_OR_OP, `EXE_ORI_OP:     logic_res = reg1_i | reg2_i;
      `EXE_XOR_OP, `EXE_XORI_OP:   logic_res = reg1_i ^ reg2_i;
      default: begin
        arith_res = 32'd0;
        logic_res = 32'd0;
      end
    endcase
  end

  always_comb begin
    single_res = 32'd0;
    case (alusel_i)
      `EXE_RES_LOGIC: single_res = logic_res;
      `EXE_RES_ARITH: single_res = arith_res;
      // A zero-amount shift reaching IDLE's single-cycle path is a plain move of r1.
      `EXE_RES_SHIFT: single_res = is_shift_op ? reg1_i : 32'd0;
      default:        single_res = 32'd0;
    endcase
  end

  assign start       = (state == S_IDLE) && is_shift_op && (shamt != 5'd0);
  assign final_cycle = (state == S_SHIFT) && (cnt <= STEP6);
  assign acc_step    = do_shift(sh_kind, acc, STEP6);
  assign shift_out   = do_shift(sh_kind, acc, cnt);

  always_comb begin
    cand_wreg = wreg_i;
    cand_wd   = wd_i;
    cand_data = single_res;
    if (state == S_SHIFT) begin
      cand_wreg = sh_wreg;
      cand_wd   = sh_wd;
      cand_data = shift_out;
    end
  end

  assign out_valid   = !rst && !flush && (((state == S_IDLE) && !start) || final_cycle);
  assign stallreq    = !rst && !flush && (start || ((state == S_SHIFT) && !final_cycle));
  assign fwd_wreg_o  = out_valid && cand_wreg;
  assign fwd_wd_o    = out_valid ? cand_wd : 5'd0;
  assign fwd_wdata_o = out_valid ? cand_data : 32'd0;
  assign dbg_state   = (state == S_SHIFT);

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_SHIFT;
        S_SHIFT: if (final_cycle) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      acc     <= 32'd0;
      cnt     <= 6'd0;
      sh_kind <= K_SLL;
      sh_wd   <= 5'd0;
      sh_wreg <= 1'b0;
      wreg_o  <= 1'b0;
      wd_o    <= 5'd0;
      wdata_o <= 32'd0;
    end else begin
      state   <= state_nxt;
      // Non-valid cycles (stall, flush) register a bubble through the gated fwd bus.
      wreg_o  <= fwd_wreg_o;
      wd_o    <= fwd_wd_o;
      wdata_o <= fwd_wdata_o;
      if (!flush) begin
        if (start) begin
          acc     <= reg1_i;
          cnt     <= {1'b0, shamt};
          sh_kind <= kind_in;
          sh_wd   <= wd_i;
          sh_wreg <= wreg_i;
        end else if ((state == S_SHIFT) && !final_cycle) begin
          acc <= acc_step;
          cnt <= cnt - STEP6;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: table of single-cycle vectors plus hand-written shift, flush
// and reset sequences on two instances (SHIFT_STEP=1 and SHIFT_STEP=4).
module tb_ex_stage;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_ADDI  = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_SLT   = 8'h05;
  localparam logic [7:0] OP_SLTU  = 8'h07;
  localparam logic [7:0] OP_SLTIU = 8'h08;
  localparam logic [7:0] OP_AND   = 8'h09;
  localparam logic [7:0] OP_ORI   = 8'h0c;
  localparam logic [7:0] OP_XOR   = 8'h0d;
  localparam logic [7:0] OP_LUI   = 8'h0f;
  localparam logic [7:0] OP_AUIPC = 8'h10;
  localparam logic [7:0] OP_SLL   = 8'h11;
  localparam logic [7:0] OP_SLLI  = 8'h12;
  localparam logic [7:0] OP_SRLI  = 8'h14;
  localparam logic [7:0] OP_SRAI  = 8'h16;
  localparam logic [2:0] RS_NOP   = 3'b000;
  localparam logic [2:0] RS_LOGIC = 3'b001;
  localparam logic [2:0] RS_SHIFT = 3'b010;
  localparam logic [2:0] RS_ARITH = 3'b100;

  typedef struct {
    string       name;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] exp_data;
    logic        exp_wreg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, flush, wreg;
  logic [31:0] pc, r1, r2;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [4:0]  wd;

  logic        stall1, fwdw1, wrego1, dbg1, stall4, fwdw4, wrego4, dbg4;
  logic [4:0]  fwdwd1, wdo1, fwdwd4, wdo4;
  logic [31:0] fwdd1, wdata1, fwdd4, wdata4;

  logic        use4;
  logic        s_stall, s_fwd_wreg, s_wreg_o, s_dbg;
  logic [4:0]  s_wd_o;
  logic [31:0] s_fwd_data, s_wdata_o;

  int checks = 0;
  int failures = 0;
  vec_t vecs[14];

  always #5 clk = ~clk;

  ex_stage #(.SHIFT_STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .pc_i(pc), .aluop_i(aluop), .alusel_i(alusel),
    .reg1_i(r1), .reg2_i(r2), .wd_i(wd), .wreg_i(wreg), .stallreq(stall1),
    .fwd_wreg_o(fwdw1), .fwd_wd_o(fwdwd1), .fwd_wdata_o(fwdd1), .wreg_o(wrego1),
    .wd_o(wdo1), .wdata_o(wdata1), .dbg_state(dbg1)
  );

  ex_stage #(.SHIFT_STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush), .pc_i(pc), .aluop_i(aluop), .alusel_i(alusel),
    .reg1_i(r1), .reg2_i(r2), .wd_i(wd), .wreg_i(wreg), .stallreq(stall4),
    .fwd_wreg_o(fwdw4), .fwd_wd_o(fwdwd4), .fwd_wdata_o(fwdd4), .wreg_o(wrego4),
    .wd_o(wdo4), .wdata_o(wdata4), .dbg_state(dbg4)
  );

  assign s_stall    = use4 ? stall4 : stall1;
  assign s_fwd_wreg = use4 ? fwdw4  : fwdw1;
  assign s_fwd_data = use4 ? fwdd4  : fwdd1;
  assign s_wreg_o   = use4 ? wrego4 : wrego1;
  assign s_wd_o     = use4 ? wdo4   : wdo1;
  assign s_wdata_o  = use4 ? wdata4 : wdata1;
  assign s_dbg      = use4 ? dbg4   : dbg1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                       input logic we);
    aluop = op; alusel = sel; pc = p; r1 = a; r2 = b; wd = d; wreg = we;
  endtask

  task automatic set_nop();
    drive(OP_NOP, RS_NOP, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0;
    set_nop();
    step();
    step();
    rst = 1'b0;
  endtask

  // Shift on the selected instance, preceded by an ADD so the bubble is visible,
  // followed by an ADD that must be accepted right after the final cycle.
  task automatic run_shift(input string name, input logic d4, input logic [7:0] op,
                           input logic [31:0] v, input logic [4:0] sh, input int exp_stalls,
                           input logic [31:0] exp_res);
    int stalls;
    logic bad;
    use4 = d4;
    stalls = 0;
    bad = 1'b0;
    drive(OP_ADD, RS_ARITH, 32'd0, 32'd1, 32'd1, 5'd1, 1'b1);
    step();
    drive(op, RS_SHIFT, 32'd0, v, {27'd0, sh}, 5'd9, 1'b1);
    #1;
    while (s_stall && stalls < 64) begin
      stalls++;
      if (s_fwd_wreg) bad = 1'b1;
      step();
      if (s_wreg_o) bad = 1'b1;
    end
    chk({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    chk({name, "_bubble_during_stall"}, {31'd0, bad}, 32'd0);
    chk({name, "_final_fwd_wreg"}, {31'd0, s_fwd_wreg}, 32'd1);
    chk({name, "_final_fwd_data"}, s_fwd_data, exp_res);
    step();
    chk({name, "_wreg_o"}, {31'd0, s_wreg_o}, 32'd1);
    chk({name, "_wd_o"}, {27'd0, s_wd_o}, 32'd9);
    chk({name, "_wdata_o"}, s_wdata_o, exp_res);
    chk({name, "_back_idle"}, {31'd0, s_dbg}, 32'd0);
    drive(OP_ADD, RS_ARITH, 32'd0, 32'd10, 32'd20, 5'd4, 1'b1);
    #1;
    chk({name, "_next_no_stall"}, {31'd0, s_stall}, 32'd0);
    chk({name, "_next_fwd_data"}, s_fwd_data, 32'd30);
    step();
    chk({name, "_next_wdata_o"}, s_wdata_o, 32'd30);
    chk({name, "_next_wd_o"}, {27'd0, s_wd_o}, 32'd4);
  endtask

  initial begin
    logic appeared;
    vecs[0]  = '{"addi",     OP_ADDI,  RS_ARITH, 32'h0,   32'h5,        32'hFFFFFFFD, 5'd3,  1'b1, 32'h2,        1'b1};
    vecs[1]  = '{"slt",      OP_SLT,   RS_ARITH, 32'h0,   32'hFFFFFFFF, 32'h1,        5'd7,  1'b1, 32'h1,        1'b1};
    vecs[2]  = '{"sltu",     OP_SLTU,  RS_ARITH, 32'h0,   32'hFFFFFFFF, 32'h1,        5'd8,  1'b1, 32'h0,        1'b1};
    vecs[3]  = '{"auipc",    OP_AUIPC, RS_ARITH, 32'h100, 32'h1000,     32'h0,        5'd10, 1'b1, 32'h1100,     1'b1};
    vecs[4]  = '{"sub",      OP_SUB,   RS_ARITH, 32'h0,   32'h3,        32'h5,        5'd11, 1'b1, 32'hFFFFFFFE, 1'b1};
    vecs[5]  = '{"and",      OP_AND,   RS_LOGIC, 32'h0,   32'hF0F0F0F0, 32'hFF00FF00, 5'd12, 1'b1, 32'hF000F000, 1'b1};
    vecs[6]  = '{"ori",      OP_ORI,   RS_LOGIC, 32'h0,   32'h0F0F0000, 32'h000000FF, 5'd13, 1'b1, 32'h0F0F00FF, 1'b1};
    vecs[7]  = '{"xor",      OP_XOR,   RS_LOGIC, 32'h0,   32'hAAAAAAAA, 32'hFFFFFFFF, 5'd14, 1'b1, 32'h55555555, 1'b1};
    vecs[8]  = '{"lui",      OP_LUI,   RS_ARITH, 32'h0,   32'h12345000, 32'h0,        5'd15, 1'b1, 32'h12345000, 1'b1};
    vecs[9]  = '{"add_wrap", OP_ADD,   RS_ARITH, 32'h0,   32'hFFFFFFFF, 32'h1,        5'd16, 1'b1, 32'h0,        1'b1};
    vecs[10] = '{"sltiu",    OP_SLTIU, RS_ARITH, 32'h0,   32'h1,        32'hFFFFFFFF, 5'd17, 1'b1, 32'h1,        1'b1};
    vecs[11] = '{"unknown",  8'hFF,    RS_ARITH, 32'h0,   32'h1234,     32'h5678,     5'd18, 1'b1, 32'h0,        1'b1};
    vecs[12] = '{"slli_0",   OP_SLLI,  RS_SHIFT, 32'h0,   32'hDEADBEEF, 32'h0,        5'd19, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[13] = '{"add_nowe", OP_ADD,   RS_ARITH, 32'h0,   32'h1,        32'h2,        5'd20, 1'b0, 32'h3,        1'b0};

    use4 = 1'b0;
    rst = 1'b1; flush = 1'b0;
    set_nop();
    step();
    step();
    chk("reset_wreg_o", {31'd0, wrego1}, 32'd0);
    chk("reset_wd_o", {27'd0, wdo1}, 32'd0);
    chk("reset_wdata_o", wdata1, 32'd0);
    chk("reset_stallreq", {31'd0, stall1}, 32'd0);
    chk("reset_fwd_wreg", {31'd0, fwdw1}, 32'd0);
    chk("reset_state", {31'd0, dbg1}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].aluop, vecs[i].alusel, vecs[i].pc, vecs[i].r1, vecs[i].r2, vecs[i].wd,
            vecs[i].wreg);
      #1;
      chk({vecs[i].name, "_stall"}, {31'd0, stall1}, 32'd0);
      chk({vecs[i].name, "_fwd_wreg"}, {31'd0, fwdw1}, {31'd0, vecs[i].exp_wreg});
      chk({vecs[i].name, "_fwd_data"}, fwdd1, vecs[i].exp_data);
      step();
      chk({vecs[i].name, "_wreg_o"}, {31'd0, wrego1}, {31'd0, vecs[i].exp_wreg});
      chk({vecs[i].name, "_wd_o"}, {27'd0, wdo1}, {27'd0, vecs[i].wd});
      chk({vecs[i].name, "_wdata_o"}, wdata1, vecs[i].exp_data);
    end

    do_reset();
    run_shift("srai7_step1", 1'b0, OP_SRAI, 32'h80000000, 5'd7, 7, 32'hFF000000);
    do_reset();
    run_shift("sll31_step4", 1'b1, OP_SLL, 32'h00000001, 5'd31, 8, 32'h80000000);
    do_reset();
    run_shift("srli5_step4", 1'b1, OP_SRLI, 32'hF0000000, 5'd5, 2, 32'h07800000);

    do_reset();
    use4 = 1'b1;
    drive(OP_SLL, RS_SHIFT, 32'd0, 32'h12, 32'h20, 5'd2, 1'b1);
    #1;
    chk("sll0_step4_stall", {31'd0, s_stall}, 32'd0);
    chk("sll0_step4_fwd", s_fwd_data, 32'h12);
    step();
    chk("sll0_step4_wdata_o", s_wdata_o, 32'h12);

    // flush on the second SHIFT cycle
    do_reset();
    use4 = 1'b0;
    drive(OP_SRLI, RS_SHIFT, 32'd0, 32'hF0000000, 32'd10, 5'd6, 1'b1);
    step();
    step();
    flush = 1'b1;
    #1;
    chk("flush_stallreq", {31'd0, stall1}, 32'd0);
    chk("flush_fwd_wreg", {31'd0, fwdw1}, 32'd0);
    step();
    flush = 1'b0;
    chk("flush_wreg_o", {31'd0, wrego1}, 32'd0);
    chk("flush_wdata_o", wdata1, 32'd0);
    chk("flush_state_idle", {31'd0, dbg1}, 32'd0);
    drive(OP_ADD, RS_ARITH, 32'd0, 32'd7, 32'd8, 5'd6, 1'b1);
    #1;
    chk("post_flush_fwd", fwdd1, 32'd15);
    step();
    chk("post_flush_wdata_o", wdata1, 32'd15);
    chk("post_flush_wreg_o", {31'd0, wrego1}, 32'd1);

    // reset on the third SHIFT cycle
    do_reset();
    drive(OP_SLLI, RS_SHIFT, 32'd0, 32'h1, 32'd20, 5'd5, 1'b1);
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("midrst_stall_comb", {31'd0, stall1}, 32'd0);
    step();
    chk("midrst_wreg_o", {31'd0, wrego1}, 32'd0);
    chk("midrst_wd_o", {27'd0, wdo1}, 32'd0);
    chk("midrst_wdata_o", wdata1, 32'd0);
    chk("midrst_stallreq", {31'd0, stall1}, 32'd0);
    chk("midrst_state", {31'd0, dbg1}, 32'd0);
    rst = 1'b0;
    set_nop();
    appeared = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (wrego1 || wdata1 == 32'h00100000) appeared = 1'b1;
    end
    chk("midrst_no_result", {31'd0, appeared}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
